// File: rtl/irq_ctrl_param.sv
// irq_ctrl_param: parametrised peripheral interrupt controller.
// Synchronises NUM_CH raw IRQ lines, latches pending state per channel
// (edge or level), masks with ENABLE and drives the core irq vector at
// IRQ_OFFSET. Fixed priority claim: channel 0 is highest.
module irq_ctrl_param #(
    parameter int NUM_CH      = 3,
    parameter int IRQ_OFFSET  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NUM_CH-1:0] irq_i,
    input  logic              wren_i,
    input  logic              rden_i,
    input  logic [2:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic [31:0]       irq_o,
    output logic              irq_any_o
);

    localparam logic [2:0] ADDR_ENABLE  = 3'd0;
    localparam logic [2:0] ADDR_MODE    = 3'd1;
    localparam logic [2:0] ADDR_PENDING = 3'd2;
    localparam logic [2:0] ADDR_CLAIM   = 3'd3;
    localparam logic [2:0] ADDR_RAW     = 3'd4;

    logic [NUM_CH-1:0] sync_w;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] rise_w;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_nxt;
    logic [NUM_CH-1:0] enable_q;
    logic [NUM_CH-1:0] mode_q;
    logic [NUM_CH-1:0] wmask_w;
    logic [NUM_CH-1:0] w1c_clr;
    logic [NUM_CH-1:0] claim_clr;
    logic [NUM_CH-1:0] mode_up;
    logic [NUM_CH-1:0] claim_oh;
    logic              claim_valid;
    logic [4:0]        claim_idx;
    logic [31:0]       rd_data;
    logic [31:0]       irq_vec;
    logic              wr_enable;
    logic              wr_mode;
    logic              wr_pending;
    logic              rd_claim;
    logic              unused_wdata;

    assign wmask_w      = wdata_i[NUM_CH-1:0];
    assign unused_wdata = ^wdata_i[31:NUM_CH];

    assign wr_enable  = wren_i && (addr_i == ADDR_ENABLE);
    assign wr_mode    = wren_i && (addr_i == ADDR_MODE);
    assign wr_pending = wren_i && (addr_i == ADDR_PENDING);
    assign rd_claim   = rden_i && (addr_i == ADDR_CLAIM);

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_w = irq_i;
        end else begin : g_sync
            logic [NUM_CH-1:0] stage_q [SYNC_STAGES];

            // Input synchroniser chain, stage 0 samples the raw lines.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= irq_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign sync_w = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rise_w = sync_w & ~prev_q;

    // Lowest-index enabled pending channel wins the claim.
    always_comb begin
        claim_valid = 1'b0;
        claim_idx   = '0;
        claim_oh    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pend_q[k] && enable_q[k]) begin
                claim_valid = 1'b1;
                claim_idx   = 5'(k);
                claim_oh    = '0;
                claim_oh[k] = 1'b1;
            end
        end
    end

    // Clear sources only touch edge-mode channels; a level->edge switch
    // drops the pending bit unless a fresh rise arrives in that cycle.
    always_comb begin
        w1c_clr   = wr_pending ? (wmask_w & mode_q) : '0;
        claim_clr = (rd_claim && claim_valid) ? (claim_oh & mode_q) : '0;
        mode_up   = wr_mode ? (wmask_w & ~mode_q) : '0;
        pend_nxt  = (mode_q & (rise_w | (pend_q & ~(w1c_clr | claim_clr))))
                  | (~mode_q & ~mode_up & sync_w)
                  | (~mode_q & mode_up & rise_w);
    end

    // Register read mux; values are the ones before any same-cycle write.
    always_comb begin
        rd_data = '0;
        case (addr_i)
            ADDR_ENABLE:  rd_data = 32'(enable_q);
            ADDR_MODE:    rd_data = 32'(mode_q);
            ADDR_PENDING: rd_data = 32'(pend_q);
            ADDR_CLAIM:   rd_data = claim_valid ? {1'b1, 26'd0, claim_idx} : '0;
            ADDR_RAW:     rd_data = 32'(sync_w);
            default:      rd_data = '0;
        endcase
    end

    // Place the masked pending bits at the configured offset.
    always_comb begin
        irq_vec = '0;
        irq_vec[IRQ_OFFSET +: NUM_CH] = pend_q & enable_q;
    end

    // Edge history, pending latch and configuration registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q   <= '0;
            pend_q   <= '0;
            enable_q <= '0;
            mode_q   <= '1;
        end else begin
            prev_q <= sync_w;
            pend_q <= pend_nxt;
            if (wr_enable) begin
                enable_q <= wmask_w;
            end
            if (wr_mode) begin
                mode_q <= wmask_w;
            end
        end
    end

    // Registered outputs: irq vector, summary flag and read response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_o     <= '0;
            irq_any_o <= 1'b0;
            rdata_o   <= '0;
            rvalid_o  <= 1'b0;
        end else begin
            irq_o     <= irq_vec;
            irq_any_o <= |(pend_q & enable_q);
            rvalid_o  <= rden_i;
            if (rden_i) begin
                rdata_o <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl_param.sv
// Bench for irq_ctrl_param: directed plan items plus a random phase, all
// checked against a cycle-stepped behavioural model of the register rules.
module tb_irq_ctrl_param;

    localparam int NUM_CH      = 3;
    localparam int IRQ_OFFSET  = 4;
    localparam int SYNC_STAGES = 2;

    logic              clk_i   = 1'b0;
    logic              rst_n_i = 1'b0;
    logic [NUM_CH-1:0] irq_i   = '0;
    logic              wren_i  = 1'b0;
    logic              rden_i  = 1'b0;
    logic [2:0]        addr_i  = '0;
    logic [31:0]       wdata_i = '0;
    logic [31:0]       rdata_o;
    logic              rvalid_o;
    logic [31:0]       irq_o;
    logic              irq_any_o;

    always #5 clk_i = ~clk_i;

    irq_ctrl_param #(
        .NUM_CH     (NUM_CH),
        .IRQ_OFFSET (IRQ_OFFSET),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .irq_i    (irq_i),
        .wren_i   (wren_i),
        .rden_i   (rden_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .irq_o    (irq_o),
        .irq_any_o(irq_any_o)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [NUM_CH-1:0] hist_q[$];
    logic [NUM_CH-1:0] m_sync, m_prev, m_pend, m_en, m_mode;
    logic [31:0]       m_irq, m_rdata;
    logic              m_any, m_rvalid;

    task automatic model_reset();
        hist_q = {};
        for (int i = 0; i < SYNC_STAGES; i++) hist_q.push_back('0);
        m_sync = '0; m_prev = '0; m_pend = '0; m_en = '0; m_mode = '1;
        m_irq = '0; m_rdata = '0; m_any = 1'b0; m_rvalid = 1'b0;
    endtask

    function automatic int lowest(input logic [NUM_CH-1:0] v);
        for (int k = 0; k < NUM_CH; k++) if (v[k]) return k;
        return -1;
    endfunction

    // One rising edge of the spec's behaviour, using inputs held before the edge.
    task automatic model_step();
        logic [NUM_CH-1:0] rise, nxt;
        logic [31:0] rd;
        logic cleared;
        int c;
        rise = m_sync & ~m_prev;
        c = lowest(m_pend & m_en);
        if (rden_i) begin
            case (addr_i)
                3'd0: rd = 32'(m_en);
                3'd1: rd = 32'(m_mode);
                3'd2: rd = 32'(m_pend);
                3'd3: rd = (c < 0) ? 32'd0 : (32'h8000_0000 + 32'(c));
                3'd4: rd = 32'(m_sync);
                default: rd = 32'd0;
            endcase
            m_rdata = rd;
        end
        m_rvalid = rden_i;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m_mode[k]) begin
                cleared = (wren_i && addr_i == 3'd2 && wdata_i[k]) ||
                          (rden_i && addr_i == 3'd3 && c == k);
                nxt[k] = rise[k] | (m_pend[k] & ~cleared);
            end else if (wren_i && addr_i == 3'd1 && wdata_i[k]) begin
                nxt[k] = rise[k];
            end else begin
                nxt[k] = m_sync[k];
            end
        end
        m_irq = '0;
        for (int k = 0; k < NUM_CH; k++) m_irq[IRQ_OFFSET + k] = m_pend[k] & m_en[k];
        m_any = |(m_pend & m_en);
        m_pend = nxt;
        if (wren_i && addr_i == 3'd0) m_en = wdata_i[NUM_CH-1:0];
        if (wren_i && addr_i == 3'd1) m_mode = wdata_i[NUM_CH-1:0];
        m_prev = m_sync;
        hist_q.push_back(irq_i);
        void'(hist_q.pop_front());
        m_sync = hist_q[0];
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        #1;
        chk("irq_o", irq_o, m_irq);
        chk("irq_any", 32'(irq_any_o), 32'(m_any));
        chk("rvalid", 32'(rvalid_o), 32'(m_rvalid));
        chk("rdata", rdata_o, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wren_i = 1'b1; addr_i = a; wdata_i = d;
        cycle();
        wren_i = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        rden_i = 1'b1; addr_i = a;
        cycle();
        rden_i = 1'b0;
        d = rdata_o;
    endtask

    logic [31:0] v;

    initial begin
        model_reset();
        #1;
        chk("rst_irq_o", irq_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_any", 32'(irq_any_o), 32'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(2);
        rd(3'd1, v); chk("rst_mode", v, 32'h7);
        rd(3'd0, v); chk("rst_enable", v, 32'h0);

        // 1: edge latency
        wr(3'd0, 32'h7);
        irq_i = 3'b010;
        cycle();
        irq_i = '0;
        cycle(); cycle();
        chk("t1_early", irq_o, 32'h0);
        cycle();
        chk("t1_lat", irq_o, 32'h20);
        chk("t1_any", 32'(irq_any_o), 32'd1);
        rd(3'd2, v); chk("t1_pend", v, 32'h2);

        // 2: claim ordering
        wr(3'd2, 32'h7);
        irq_i = 3'b101;
        cycle();
        irq_i = '0;
        idle(4);
        rd(3'd3, v); chk("t2_claim0", v, 32'h8000_0000);
        rd(3'd3, v); chk("t2_claim2", v, 32'h8000_0002);
        rd(3'd3, v); chk("t2_none", v, 32'h0);
        idle(2);
        chk("t2_irq_clr", irq_o, 32'h0);

        // 3: level mode
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h1);
        irq_i = 3'b001;
        idle(4);
        chk("t3_level", irq_o, 32'h10);
        wr(3'd2, 32'h1);
        idle(2);
        chk("t3_w1c_ign", irq_o, 32'h10);
        irq_i = '0;
        idle(3);
        chk("t3_hold", irq_o, 32'h10);
        cycle();
        chk("t3_drop", irq_o, 32'h0);

        // 4: latched while disabled
        wr(3'd1, 32'h7);
        wr(3'd0, 32'h0);
        irq_i = 3'b100;
        cycle();
        irq_i = '0;
        idle(4);
        chk("t4_masked", irq_o, 32'h0);
        rd(3'd2, v); chk("t4_pend", v, 32'h4);
        wren_i = 1'b1; addr_i = 3'd0; wdata_i = 32'h4;
        cycle();
        wren_i = 1'b0;
        chk("t4_wr_edge", irq_o, 32'h0);
        cycle();
        chk("t4_unmask", irq_o, 32'h40);

        // 5: claim coinciding with a new rise
        wr(3'd2, 32'h7);
        wr(3'd0, 32'h7);
        irq_i = 3'b010;
        cycle();
        irq_i = '0;
        idle(4);
        irq_i = 3'b010;
        cycle();
        irq_i = '0;
        cycle();
        rden_i = 1'b1; addr_i = 3'd3;
        cycle();
        rden_i = 1'b0;
        chk("t5_rvalid", 32'(rvalid_o), 32'd1);
        chk("t5_claim", rdata_o, 32'h8000_0001);
        rd(3'd2, v); chk("t5_pend_kept", v, 32'h2);

        // 6: async reset with a read in flight
        wr(3'd2, 32'h7);
        irq_i = 3'b011;
        cycle();
        irq_i = '0;
        idle(4);
        rd(3'd2, v); chk("t6_pend_pre", v, 32'h3);
        rden_i = 1'b1; addr_i = 3'd2;
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        chk("t6_irq_o", irq_o, 32'h0);
        chk("t6_rvalid", 32'(rvalid_o), 32'd0);
        chk("t6_rdata", rdata_o, 32'h0);
        rden_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(3);
        rd(3'd2, v); chk("t6_pend", v, 32'h0);
        rd(3'd0, v); chk("t6_enable", v, 32'h0);
        rd(3'd1, v); chk("t6_mode", v, 32'h7);

        // Random phase against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_i = NUM_CH'($urandom);
            wren_i  = ($urandom_range(0, 4) == 0);
            rden_i  = ($urandom_range(0, 2) == 0);
            addr_i  = 3'($urandom_range(0, 7));
            wdata_i = $urandom;
            cycle();
        end
        wren_i = 1'b0; rden_i = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
